// File: rtl/mmio_periph_pkg.sv
// mmio_periph_pkg: shared definitions for the mmio_periph register block.
// Holds the register offset map, TCON/STATUS bit positions, the TX launch
// FSM state encoding and a byte-lane merge helper for partial writes.
package mmio_periph_pkg;

  // Register offsets (byte addresses, word aligned)
  localparam logic [7:0] A_RXDATA = 8'h80;
  localparam logic [7:0] A_STATUS = 8'h84;
  localparam logic [7:0] A_TXDATA = 8'h88;
  localparam logic [7:0] A_CTRL   = 8'h8C;
  localparam logic [7:0] A_LED    = 8'h90;
  localparam logic [7:0] A_DIGITS = 8'h94;
  localparam logic [7:0] A_CYCLES = 8'h98;

  // Word index inside a 16-byte timer window
  localparam logic [1:0] T_TH   = 2'd0;
  localparam logic [1:0] T_TL   = 2'd1;
  localparam logic [1:0] T_TCON = 2'd2;

  localparam int TCON_EN   = 0;
  localparam int TCON_IE   = 1;
  localparam int TCON_PEND = 2;

  localparam int ST_RX_NE    = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_RX_OVF   = 2;
  localparam int ST_TX_BUSY  = 3;
  localparam int ST_TX_FULL  = 4;
  localparam int ST_TX_EMPTY = 5;

  typedef enum logic [1:0] {
    TX_IDLE, TX_LAUNCH, TX_WAIT, TX_DRAIN
  } tx_state_t;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/periph_sync_fifo.sv
// periph_sync_fifo: 8-bit synchronous FIFO used for UART RX and TX buffering.
// Ports: clk, reset (async, active low), push/din, pop, head (current front
// byte, valid when !empty), full, empty, count.
// A push while full is dropped unless a pop happens in the same cycle; a pop
// while empty is ignored. Push+pop together keeps count unchanged.
module periph_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one popped this cycle; the
  // popped byte has already been consumed combinationally from head.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped peripheral block with NUM_TIMERS reload timers,
// buffered UART RX/TX FIFOs, LED/digit registers, a free-running cycle
// counter and an aggregated interrupt.
// Ports: clk, reset (async, active low); CPU side sel/addr/we/re/wdata
// (+be when PERI_BYTE_EN is defined) and registered rdata; UART side
// rx_data/rx_valid in, tx_data/tx_start out, tx_busy in; led, digits,
// timer_irq, irq outputs.
// Macro PERI_BYTE_EN: adds the be port; writes then touch only enabled
// bytes, TXDATA pushes only with be[0], W1C bits need their byte enabled.
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [7:0]            addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [31:0]           wdata,
`ifdef PERI_BYTE_EN
  input  logic [3:0]            be,
`endif
  output logic [31:0]           rdata,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [7:0]            led,
  output logic [11:0]           digits,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  irq
);

  logic [3:0] be_i;
`ifdef PERI_BYTE_EN
  assign be_i = be;
`else
  assign be_i = 4'hF;
`endif

  logic       wr, rd;
  logic [7:0] a;
  logic [1:0] addr_unused;
  assign wr          = sel & we;
  assign rd          = sel & re;
  assign a           = {addr[7:2], 2'b00};
  assign addr_unused = addr[1:0];

  // ---------------- timers ----------------
  logic [NUM_TIMERS-1:0][31:0] th_a, tl_a;
  logic [NUM_TIMERS-1:0]       en_a, ie_a, pend_a;

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
    logic [31:0] th, tl;
    logic        en, ie, pend, hit, wrap, tcon_wr;

    assign hit     = wr && (a[7:6] == 2'b00) && (a[5:4] == 2'(k));
    assign tcon_wr = hit && (a[3:2] == T_TCON) && be_i[0];
    assign wrap    = en && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        th <= '0; tl <= '0; en <= 1'b0; ie <= 1'b0; pend <= 1'b0;
      end else begin
        if (hit && a[3:2] == T_TH) th <= be_merge(th, wdata, be_i);
        // CPU write to TL beats reload/increment
        if (hit && a[3:2] == T_TL) tl <= be_merge(tl, wdata, be_i);
        else if (wrap)              tl <= th;
        else if (en)                tl <= tl + 32'd1;
        if (tcon_wr) begin
          en <= wdata[TCON_EN];
          ie <= wdata[TCON_IE];
        end
        // a new expiry beats a simultaneous W1C
        if (wrap && ie)                          pend <= 1'b1;
        else if (tcon_wr && wdata[TCON_PEND])    pend <= 1'b0;
      end
    end

    assign th_a[k]      = th;
    assign tl_a[k]      = tl;
    assign en_a[k]      = en;
    assign ie_a[k]      = ie;
    assign pend_a[k]    = pend;
    assign timer_irq[k] = pend & ie;
  end

  // ---------------- UART FIFOs ----------------
  logic [7:0]       rx_head, tx_head;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             rx_pop, tx_push, tx_pop, rx_ovf, rx_ie;
  logic [FIFO_AW:0] rx_cnt_unused, tx_cnt_unused;

  assign rx_pop  = rd && (a == A_RXDATA);
  assign tx_push = wr && (a == A_TXDATA) && be_i[0];

  periph_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_valid), .pop(rx_pop), .din(rx_data),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt_unused)
  );

  periph_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_cnt_unused)
  );

  // ---------------- TX launch FSM ----------------
  tx_state_t tx_st, tx_st_nx;
  logic      wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st    <= TX_IDLE;
      wait_cnt <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_st    <= tx_st_nx;
      wait_cnt <= (tx_st == TX_WAIT);
      // capture head on entry to LAUNCH; it is stable until the LAUNCH pop
      if (tx_st == TX_IDLE && tx_st_nx == TX_LAUNCH) tx_data <= tx_head;
    end
  end

  always_comb begin
    tx_st_nx = tx_st;
    tx_start = 1'b0;
    tx_pop   = 1'b0;
    case (tx_st)
      TX_IDLE:   if (!tx_empty && !tx_busy) tx_st_nx = TX_LAUNCH;
      TX_LAUNCH: begin
        tx_start = 1'b1;
        tx_pop   = 1'b1;
        tx_st_nx = TX_WAIT;
      end
      // give the UART up to two cycles to raise busy
      TX_WAIT:   if (tx_busy || wait_cnt) tx_st_nx = TX_DRAIN;
      TX_DRAIN:  if (!tx_busy) tx_st_nx = TX_IDLE;
      default:   tx_st_nx = TX_IDLE;
    endcase
  end

  // ---------------- misc registers ----------------
  logic [31:0] cycles;
  logic        sts_w1c;
  assign sts_w1c = wr && (a == A_STATUS) && be_i[0] && wdata[ST_RX_OVF];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led    <= '0;
      digits <= '0;
      rx_ie  <= 1'b0;
      rx_ovf <= 1'b0;
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (wr && a == A_LED && be_i[0])    led          <= wdata[7:0];
      if (wr && a == A_DIGITS && be_i[0]) digits[7:0]  <= wdata[7:0];
      if (wr && a == A_DIGITS && be_i[1]) digits[11:8] <= wdata[11:8];
      if (wr && a == A_CTRL && be_i[0])   rx_ie        <= wdata[0];
      if (rx_valid && rx_full && !rx_pop) rx_ovf <= 1'b1;
      else if (sts_w1c)                   rx_ovf <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (a[7:6] == 2'b00) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (a[5:4] == 2'(i)) begin
          case (a[3:2])
            T_TH:    rd_mux = th_a[i];
            T_TL:    rd_mux = tl_a[i];
            T_TCON:  rd_mux = {29'b0, pend_a[i], ie_a[i], en_a[i]};
            default: rd_mux = '0;
          endcase
        end
      end
    end else begin
      case (a)
        A_RXDATA: rd_mux = rx_empty ? 32'h0 : {24'b0, rx_head};
        A_STATUS: rd_mux = {26'b0, tx_empty, tx_full, tx_busy,
                            rx_ovf, rx_full, ~rx_empty};
        A_CTRL:   rd_mux = {31'b0, rx_ie};
        A_LED:    rd_mux = {24'b0, led};
        A_DIGITS: rd_mux = {20'b0, digits};
        A_CYCLES: rd_mux = cycles;
        default:  rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (rd) rdata <= rd_mux;
  end

  assign irq = (|timer_irq) | (rx_ie & ~rx_empty);

endmodule

// File: tb/tb_mmio_periph.sv
module tb_mmio_periph;
  import mmio_periph_pkg::*;

  logic        clk = 1'b0, reset = 1'b0;
  logic        sel = 1'b0, we = 1'b0, re = 1'b0, rx_valid = 1'b0;
  logic [7:0]  addr = '0, rx_data = '0;
  logic [31:0] wdata = '0;
`ifdef PERI_BYTE_EN
  logic [3:0]  be = 4'hF;
`endif
  logic [31:0] rdata;
  logic [7:0]  tx_data, led;
  logic        tx_start, tx_busy, irq;
  logic [11:0] digits;
  logic [1:0]  timer_irq;

  int n_vec = 0, n_err = 0, n_tx = 0, busy_cnt = 0;
  logic        rd_fire = 1'b0;
  logic [31:0] rd_q[$];
  string       rd_tag_q[$];
  logic [7:0]  tx_q[$];

  mmio_periph #(.NUM_TIMERS(2), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we), .re(re),
    .wdata(wdata),
`ifdef PERI_BYTE_EN
    .be(be),
`endif
    .rdata(rdata), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .led(led), .digits(digits), .timer_irq(timer_irq), .irq(irq)
  );

  always #5 clk = ~clk;
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // UART TX model: busy for 10 cycles after each start
  always @(posedge clk) begin
    rd_fire <= sel & re;
    if (!reset)                busy_cnt <= 0;
    else if (tx_start)         busy_cnt <= 10;
    else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
  end

  // scoreboard: reads and TX launches
  always @(negedge clk) begin
    if (rd_fire) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk(rd_tag_q.pop_front(), rdata, rd_q.pop_front());
    end
    if (tx_start) begin
      n_tx++;
      chk("tx_busy_at_start", {31'b0, tx_busy}, 32'd0);
      if (tx_q.size() == 0) chk("tx_unexpected", {24'b0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
    end
  end

  // bus tasks: called at a negedge, return at the next negedge
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
`ifdef PERI_BYTE_EN
    be = 4'hF;
`endif
    @(negedge clk); sel = 1'b0; we = 1'b0;
  endtask

`ifdef PERI_BYTE_EN
  task automatic wr_be(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk); sel = 1'b0; we = 1'b0; be = 4'hF;
  endtask
`endif

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    sel = 1'b1; re = 1'b1; addr = a;
    rd_q.push_back(exp); rd_tag_q.push_back(tag);
    @(negedge clk); sel = 1'b0; re = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_led", {24'b0, led}, 32'd0);
    chk("rst_digits", {20'b0, digits}, 32'd0);
    reset = 1'b1;
    rd("cycles0", A_CYCLES, 32'd0);
    rd("cycles1", A_CYCLES, 32'd1);

    // ---- timer 0 reload + W1C ----
    wr(8'h00, 32'hFFFF_FFF0);
    wr(8'h04, 32'hFFFF_FFFD);
    wr(8'h08, 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("tmr_irq_early", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("tmr_irq", {31'b0, irq}, 32'd1);
    chk("tmr_tirq", {30'b0, timer_irq}, 32'd1);
    rd("tmr_tl_reload", 8'h04, 32'hFFFF_FFF0);
    rd("tmr_tcon", 8'h08, 32'd7);
    wr(8'h08, 32'd7);
    chk("tmr_irq_w1c", {31'b0, irq}, 32'd0);
    wr(8'h08, 32'd0);
    repeat (5) @(negedge clk);
    rd("tmr_tl_hold", 8'h04, 32'hFFFF_FFF4);
    rd("tmr1_tl", 8'h14, 32'd0);
    wr(8'h24, 32'h1234_5678);
    rd("tmr2_unmapped", 8'h24, 32'd0);
    rd("tmr_reserved", 8'h0C, 32'd0);
    wr(A_DIGITS, 32'hFFFF_FABC);
    rd("digits", A_DIGITS, 32'h0000_0ABC);

    // ---- RX overflow ----
    wr(A_CTRL, 32'd1);
    chk("rx_irq_empty", {31'b0, irq}, 32'd0);
    for (int i = 1; i <= 9; i++) rx_push(8'(i));
    chk("rx_irq", {31'b0, irq}, 32'd1);
    rd("rx_status_ovf", A_STATUS, 32'h27);
    for (int i = 1; i <= 8; i++) rd("rx_data", A_RXDATA, 32'(i));
    rd("rx_empty_read", A_RXDATA, 32'd0);
    rd("rx_status_sticky", A_STATUS, 32'h24);
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd("rx_status_clr", A_STATUS, 32'h20);
    chk("rx_irq_drained", {31'b0, irq}, 32'd0);

    // ---- RX push+pop while full ----
    for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
    sel = 1'b1; re = 1'b1; addr = A_RXDATA; rx_valid = 1'b1; rx_data = 8'h18;
    rd_q.push_back(32'h10); rd_tag_q.push_back("rx_full_pop");
    @(negedge clk);
    sel = 1'b0; re = 1'b0; rx_valid = 1'b0;
    rd("rx_full_status", A_STATUS, 32'h23);
    for (int i = 1; i <= 8; i++) rd("rx_order", A_RXDATA, 32'h10 + 32'(i));
    rd("rx_status_end", A_STATUS, 32'h20);

    // ---- TX launch ----
    tx_q.push_back(8'h41); wr(A_TXDATA, 32'h41);
    tx_q.push_back(8'h42); wr(A_TXDATA, 32'h42);
    for (int c = 0; c < 100 && n_tx < 2; c++) @(negedge clk);
    chk("tx_pulses", 32'(n_tx), 32'd2);
    repeat (15) @(negedge clk);
    chk("tx_pulses_final", 32'(n_tx), 32'd2);
    chk("tx_data_hold", {24'b0, tx_data}, 32'h42);

    // ---- reset mid-drain ----
    wr(A_LED, 32'hA5);
    rd("led", A_LED, 32'hA5);
    tx_q.push_back(8'h55); wr(A_TXDATA, 32'h55);
    wr(A_TXDATA, 32'h66);
    for (int c = 0; c < 100 && n_tx < 3; c++) @(negedge clk);
    chk("tx_third", 32'(n_tx), 32'd3);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    chk("mid_rst_led", {24'b0, led}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd("rst_cycles", A_CYCLES, 32'd0);
    rd("rst_status", A_STATUS, 32'h20);
    repeat (30) @(negedge clk);
    chk("tx_dropped_by_reset", 32'(n_tx), 32'd3);

`ifdef PERI_BYTE_EN
    rd("be_led0", A_LED, 32'd0);
    wr_be(A_LED, 32'hFFFF_FF5A, 4'b0001);
    rd("be_led", A_LED, 32'h5A);
    wr_be(A_LED, 32'h0000_00FF, 4'b1110);
    rd("be_led_masked", A_LED, 32'h5A);
    wr_be(A_TXDATA, 32'h77, 4'b0000);
    repeat (10) @(negedge clk);
    chk("be_tx_nopush", 32'(n_tx), 32'd3);
    rd("be_status", A_STATUS, 32'h20);
`endif

    repeat (2) @(negedge clk);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
